// File: rtl/or_and_selector.sv
// or_and_selector: registered 8-bit bitwise unit combining ui_in with uio_in.
// ui_in[7] picks the operation (0 = AND, 1 = OR). The result is registered,
// so there is exactly one clock of latency and no combinational path to uo_out.
// The bidirectional pins are used only as inputs, so their output side is tied off.
module or_and_selector (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       op_sel;
  logic [7:0] result_d;
  logic [7:0] result_q;

  assign op_sel = ui_in[7];

  // Select between bitwise OR and AND of the two operand buses.
  always_comb begin
    result_d = ui_in & uio_in;
    if (op_sel) begin
      result_d = ui_in | uio_in;
    end
  end

  // Result register: cleared immediately by reset, loads only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 8'h00;
    end else if (ena) begin
      result_q <= result_d;
    end
  end

  assign uo_out  = result_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_or_and_selector.sv
// Testbench for or_and_selector: directed cases plus randomized traffic,
// checked against a bit-by-bit arithmetic reference model with hold behaviour.
module tb_or_and_selector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model_q = 8'h00;

  or_and_selector dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Reference: per-bit arithmetic. AND is a product of bits, OR is "sum > 0".
  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b);
    int r;
    int use_or;
    r = 0;
    use_or = (int'(a) >= 128) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      int ba;
      int bb;
      int bit_r;
      ba = (int'(a) >> i) % 2;
      bb = (int'(b) >> i) % 2;
      bit_r = use_or ? (((ba + bb) > 0) ? 1 : 0) : (ba * bb);
      r = r + bit_r * (1 << i);
    end
    return r[7:0];
  endfunction

  // Drive inputs on the falling edge, take one rising edge, advance model, settle.
  task automatic apply(input logic en, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    ena    = en;
    ui_in  = a;
    uio_in = b;
    @(posedge clk);
    if (en && rst_n) model_q = ref_op(a, b);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hC3;
    uio_in = 8'h5A;
    #12;
    vectors++;
    if (uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_uo_out: got %h expected %h", uo_out, 8'h00);
    end
    vectors++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_tieoffs: got uio_out %h uio_oe %h expected 00 00", uio_out, uio_oe);
    end
    model_q = 8'h00;
    // Release with ena low: output must stay cleared until an enabled edge.
    @(negedge clk);
    ena = 1'b0;
    rst_n = 1'b1;
    apply(1'b0, 8'hFF, 8'hFF);
    vectors++;
    if (uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_release_hold: got %h expected %h", uo_out, 8'h00);
    end
    apply(1'b1, 8'h81, 8'h10);
    vectors++;
    if (uo_out !== 8'h91 || uo_out !== model_q) begin
      miscompares++;
      $display("FAIL reset_first_load: got %h expected %h", uo_out, 8'h91);
    end
    // Asynchronous assertion between edges clears the held value at once.
    #2;
    rst_n = 1'b0;
    #1;
    model_q = 8'h00;
    vectors++;
    if (uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", uo_out, 8'h00);
    end
    vectors++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async_tieoffs: got uio_out %h uio_oe %h expected 00 00", uio_out, uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] da [4];
    logic [7:0] db [4];
    logic [7:0] dexp [4];
    da[0] = 8'b00010100; db[0] = 8'b00011110; dexp[0] = 8'b00010100;
    da[1] = 8'b10010100; db[1] = 8'b00011110; dexp[1] = 8'b10011110;
    da[2] = 8'h00;       db[2] = 8'h00;       dexp[2] = 8'h00;
    da[3] = 8'hFF;       db[3] = 8'b10101010; dexp[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, da[i], db[i]);
      vectors++;
      if (uo_out !== dexp[i] || uo_out !== model_q) begin
        miscompares++;
        $display("FAIL directed_%0d: got %h expected %h (model %h)", i, uo_out, dexp[i], model_q);
      end
    end
  endtask

  task automatic test_hold_latency();
    apply(1'b1, 8'hA5, 8'h0F);
    vectors++;
    if (uo_out !== 8'hAF) begin
      miscompares++;
      $display("FAIL hold_load: got %h expected %h", uo_out, 8'hAF);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 8'h33 + 8'(i), 8'hF0 - 8'(i));
      vectors++;
      if (uo_out !== 8'hAF) begin
        miscompares++;
        $display("FAIL hold_disabled_%0d: got %h expected %h", i, uo_out, 8'hAF);
      end
    end
    // Re-enable: no change before the edge, new value right after it.
    @(negedge clk);
    ena    = 1'b1;
    ui_in  = 8'h33;
    uio_in = 8'h0F;
    #1;
    vectors++;
    if (uo_out !== 8'hAF) begin
      miscompares++;
      $display("FAIL reenable_pre_edge: got %h expected %h", uo_out, 8'hAF);
    end
    @(posedge clk);
    model_q = ref_op(8'h33, 8'h0F);
    #1;
    vectors++;
    if (uo_out !== 8'h03 || uo_out !== model_q) begin
      miscompares++;
      $display("FAIL reenable_post_edge: got %h expected %h", uo_out, 8'h03);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic       en;
      logic [7:0] a;
      logic [7:0] b;
      en = ($urandom_range(0, 3) != 0);
      a  = 8'($urandom);
      b  = 8'($urandom);
      apply(en, a, b);
      vectors++;
      if (uo_out !== model_q) begin
        miscompares++;
        $display("FAIL random_%0d: ena %b ui_in %h uio_in %h got %h expected %h", n, en, a, b, uo_out, model_q);
      end
      if ((n % 50) == 0) begin
        vectors++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
          miscompares++;
          $display("FAIL random_tieoffs_%0d: got uio_out %h uio_oe %h expected 00 00", n, uio_out, uio_oe);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    // Flip select together with operands every cycle.
    logic [7:0] a;
    for (int n = 0; n < 16; n++) begin
      a = 8'($urandom) ^ ((n % 2 == 1) ? 8'h80 : 8'h00);
      a[7] = n[0];
      apply(1'b1, a, 8'($urandom));
      vectors++;
      if (uo_out !== model_q || uo_out[7] !== a[7]) begin
        miscompares++;
        $display("FAIL back_to_back_%0d: got %h expected %h", n, uo_out, model_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_latency();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
